// File: rtl/pipe_hazard_ctrl.sv
// Pipeline scheduler: run/halt sequencing, RAW hazard scoreboard over EX/MEM/WB,
// stall/bubble generation and post-branch flush timing for a 5-stage core.
module pipe_hazard_ctrl #(
  parameter int NREG        = 32,
  parameter int TRACK_DEPTH = 3,
  parameter int FLUSH_CYC   = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             RN,
  input  logic             start,
  input  logic             halt_req,
  input  logic             id_valid,
  input  logic [31:0]      id_ir,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             run,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int RW = $clog2(NREG);
  localparam int TW = $clog2(FLUSH_CYC + 1);

  localparam logic [6:0] OP_AR = 7'd0;
  localparam logic [6:0] OP_M  = 7'd1;
  localparam logic [6:0] OP_SH = 7'd3;
  localparam logic [2:0] F3_LW = 3'd0;
  localparam logic [2:0] F3_SW = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [TRACK_DEPTH-1:0] slot_vld_reg;
  logic [RW-1:0]          slot_rd_reg [TRACK_DEPTH];
  logic [TRACK_DEPTH-1:0] slot_hit;
  logic [TW-1:0]          flush_tmr_reg;
  logic [CNT_W-1:0]       stall_cnt_reg;
  logic [CNT_W-1:0]       flush_cnt_reg;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [RW-1:0] rd_f, rs1_f, rs2_f, src_b;
  logic          use_a, use_b, writes;
  logic          advance, hazard, issue, br_accept;
  logic          unused_ir;

  assign opcode    = id_ir[6:0];
  assign funct3    = id_ir[14:12];
  assign rd_f      = id_ir[7 +: RW];
  assign rs1_f     = id_ir[15 +: RW];
  assign rs2_f     = id_ir[20 +: RW];
  assign unused_ir = ^id_ir[31:25];

  // Store data is taken from the rd field, so SW reads it as a second source.
  always_comb begin
    use_a  = 1'b0;
    use_b  = 1'b0;
    writes = 1'b0;
    src_b  = rs2_f;
    case (opcode)
      OP_AR, OP_SH: begin
        use_a  = 1'b1;
        use_b  = 1'b1;
        writes = 1'b1;
      end
      OP_M: begin
        if (funct3 == F3_LW) begin
          use_a  = 1'b1;
          writes = 1'b1;
        end else if (funct3 == F3_SW) begin
          use_a = 1'b1;
          use_b = 1'b1;
          src_b = rd_f;
        end
      end
      default: ;
    endcase
  end

  // WB slot is included: register write and decode read share the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < TRACK_DEPTH; gi++) begin : g_match
      assign slot_hit[gi] = slot_vld_reg[gi] &&
                            ((use_a && (rs1_f != '0) && (rs1_f == slot_rd_reg[gi])) ||
                             (use_b && (src_b != '0) && (src_b == slot_rd_reg[gi])));
    end
  endgenerate

  assign advance   = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign flush     = (flush_tmr_reg != '0);
  assign hazard    = id_valid && (state_reg == ST_RUN) && (|slot_hit);
  assign stall     = hazard && !flush;
  assign bubble    = stall;
  assign issue     = id_valid && (state_reg == ST_RUN) && !stall && !flush;
  assign br_accept = br_resolve && br_taken && advance && (flush_tmr_reg == '0);
  assign run       = advance && !stall;
  assign busy      = (|slot_vld_reg) || flush;
  assign state     = state_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (halt_req) state_next = ST_DRAIN;
      ST_DRAIN: if (!(|slot_vld_reg) && (flush_tmr_reg == '0)) state_next = ST_HALT;
      ST_HALT:  if (start) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Scoreboard shifts only while the pipeline moves; writes to r0 never enter.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      slot_vld_reg <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) slot_rd_reg[i] <= '0;
    end else if (advance) begin
      slot_vld_reg[0] <= issue && writes && (rd_f != '0);
      slot_rd_reg[0]  <= rd_f;
      for (int i = 1; i < TRACK_DEPTH; i++) begin
        slot_vld_reg[i] <= slot_vld_reg[i-1];
        slot_rd_reg[i]  <= slot_rd_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      flush_tmr_reg <= '0;
    end else if (br_accept) begin
      flush_tmr_reg <= TW'(FLUSH_CYC);
    end else if (flush_tmr_reg != '0) begin
      flush_tmr_reg <= flush_tmr_reg - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (br_accept && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard stalls, r0/store cases, branch flush,
// halt/drain sequencing and asynchronous reset mid-stall.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  localparam logic [31:0] ADD6  = 32'h0220_8300; // add r6,r1,r2
  localparam logic [31:0] SUB7  = 32'h0223_1380; // sub r7,r6,r2
  localparam logic [31:0] AND8  = 32'h0230_a400; // and r8,r1,r3
  localparam logic [31:0] OR9   = 32'h0251_3480; // or  r9,r2,r5
  localparam logic [31:0] ADD0  = 32'h0220_8000; // add r0,r1,r2
  localparam logic [31:0] SUBR0 = 32'h0220_1380; // sub r7,r0,r2
  localparam logic [31:0] ADD3  = 32'h0220_8180; // add r3,r1,r2
  localparam logic [31:0] SW13  = 32'h0020_9181; // sw  r3 -> [r1]
  localparam logic [31:0] ADD10 = 32'h0220_8500; // add r10,r1,r2

  logic             clk;
  logic             RN;
  logic             start, halt_req, id_valid, br_resolve, br_taken;
  logic [31:0]      id_ir;
  logic             run, stall, bubble, flush, busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks;
  int failures;

  pipe_hazard_ctrl #(
    .NREG(32), .TRACK_DEPTH(3), .FLUSH_CYC(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .RN(RN), .start(start), .halt_req(halt_req),
    .id_valid(id_valid), .id_ir(id_ir), .br_resolve(br_resolve), .br_taken(br_taken),
    .run(run), .stall(stall), .bubble(bubble), .flush(flush), .busy(busy),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RN = 1'b0; start = 1'b0; halt_req = 1'b0; id_valid = 1'b0;
    id_ir = 32'h0; br_resolve = 1'b0; br_taken = 1'b0;
    repeat (2) cyc();

    chk("rst_state", 32'(state), 0);
    chk("rst_run", 32'(run), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bubble", 32'(bubble), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);

    RN = 1'b1; start = 1'b1;
    #1 chk("idle_before_start", 32'(state), 0);
    cyc();
    start = 1'b0;
    #1 chk("start_state", 32'(state), 1);
    chk("start_run", 32'(run), 1);
    $display("step start: state=%0d run=%0b", state, run);

    // distance-1 dependency: 3 stall cycles
    id_valid = 1'b1; id_ir = ADD6;
    #1 chk("add_nostall", 32'(stall), 0);
    cyc();
    id_ir = SUB7;
    #1 chk("sub_stall1", 32'(stall), 1);
    chk("sub_bubble1", 32'(bubble), 1);
    chk("sub_run1", 32'(run), 0);
    cyc();
    #1 chk("sub_stall2", 32'(stall), 1);
    cyc();
    #1 chk("sub_stall3", 32'(stall), 1);
    chk("sub_bubble3", 32'(bubble), 1);
    cyc();
    #1 chk("sub_issue", 32'(stall), 0);
    chk("sub_issue_run", 32'(run), 1);
    cyc();
    id_valid = 1'b0;
    #1 chk("t1_stall_cnt", 32'(stall_cnt), 3);
    $display("step raw_d1: stall_cnt=%0d", stall_cnt);
    idle(3);

    // independent back-to-back
    id_valid = 1'b1; id_ir = ADD6;
    #1 chk("ind_add", 32'(stall), 0);
    cyc();
    id_ir = AND8;
    #1 chk("ind_and", 32'(stall), 0);
    cyc();
    id_ir = OR9;
    #1 chk("ind_or", 32'(stall), 0);
    cyc();
    id_valid = 1'b0;
    #1 chk("t2_stall_cnt", 32'(stall_cnt), 3);
    $display("step independent: stall_cnt=%0d", stall_cnt);
    idle(3);

    // r0 producer/consumer, then store reading rd field
    id_valid = 1'b1; id_ir = ADD0;
    #1 chk("r0_prod", 32'(stall), 0);
    cyc();
    id_ir = SUBR0;
    #1 chk("r0_cons", 32'(stall), 0);
    cyc();
    id_ir = ADD3;
    #1 chk("r3_prod", 32'(stall), 0);
    cyc();
    id_ir = SW13;
    #1 chk("sw_stall1", 32'(stall), 1);
    cyc();
    #1 chk("sw_stall2", 32'(stall), 1);
    cyc();
    #1 chk("sw_stall3", 32'(stall), 1);
    cyc();
    #1 chk("sw_issue", 32'(stall), 0);
    cyc();
    id_valid = 1'b0;
    #1 chk("t3_stall_cnt", 32'(stall_cnt), 6);
    $display("step r0_sw: stall_cnt=%0d", stall_cnt);
    idle(3);

    // taken branch: 2 flush cycles, wrong-path resolve ignored, flush beats stall
    id_valid = 1'b1; id_ir = ADD6; br_resolve = 1'b1; br_taken = 1'b1;
    #1 chk("br_res_flush", 32'(flush), 0);
    cyc();
    id_ir = SUB7; br_resolve = 1'b0; br_taken = 1'b0;
    #1 chk("flush_c1", 32'(flush), 1);
    chk("flush_c1_stall", 32'(stall), 0);
    chk("flush_c1_bubble", 32'(bubble), 0);
    chk("flush_c1_busy", 32'(busy), 1);
    chk("flush_c1_cnt", 32'(flush_cnt), 1);
    br_resolve = 1'b1; br_taken = 1'b1;
    cyc();
    br_resolve = 1'b0; br_taken = 1'b0;
    #1 chk("flush_c2", 32'(flush), 1);
    chk("flush_c2_stall", 32'(stall), 0);
    cyc();
    #1 chk("flush_end", 32'(flush), 0);
    chk("post_flush_stall", 32'(stall), 1);
    chk("ignored_br_cnt", 32'(flush_cnt), 1);
    cyc();
    #1 chk("post_flush_issue", 32'(stall), 0);
    cyc();
    id_valid = 1'b0;
    #1 chk("t4_stall_cnt", 32'(stall_cnt), 7);
    $display("step branch: flush_cnt=%0d stall_cnt=%0d", flush_cnt, stall_cnt);
    idle(3);

    // halt with two writes in flight; halt_req wins over start
    id_valid = 1'b1; id_ir = ADD6;
    cyc();
    id_ir = AND8;
    cyc();
    id_valid = 1'b0; halt_req = 1'b1; start = 1'b1;
    #1 chk("halt_req_state", 32'(state), 1);
    chk("halt_req_busy", 32'(busy), 1);
    cyc();
    halt_req = 1'b0; start = 1'b0; id_valid = 1'b1; id_ir = ADD10;
    #1 chk("drain1_state", 32'(state), 2);
    chk("drain1_run", 32'(run), 1);
    chk("drain1_busy", 32'(busy), 1);
    cyc();
    #1 chk("drain2_busy", 32'(busy), 1);
    cyc();
    #1 chk("drain3_state", 32'(state), 2);
    chk("drain3_busy", 32'(busy), 0);
    cyc();
    id_valid = 1'b0;
    #1 chk("halt_state", 32'(state), 3);
    chk("halt_run", 32'(run), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1 chk("restart_state", 32'(state), 1);
    chk("restart_run", 32'(run), 1);
    $display("step halt: state=%0d run=%0b", state, run);

    // asynchronous reset in the middle of a stall
    id_valid = 1'b1; id_ir = ADD6;
    cyc();
    id_ir = SUB7;
    #1 chk("pre_rst_stall", 32'(stall), 1);
    chk("pre_rst_stall_cnt", 32'(stall_cnt), 7);
    chk("pre_rst_flush_cnt", 32'(flush_cnt), 1);
    RN = 1'b0;
    #1 chk("arst_stall", 32'(stall), 0);
    chk("arst_bubble", 32'(bubble), 0);
    chk("arst_flush", 32'(flush), 0);
    chk("arst_run", 32'(run), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    chk("arst_flush_cnt", 32'(flush_cnt), 0);
    $display("step async_reset: state=%0d stall=%0b", state, stall);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
